crc8_frame_checker: RTL and testbench
=====================================

# crc8_frame_checker

Receive-side stage that consumes the single-byte CRC-8 (polynomial 1+x^2+x^3+x^5+x^8, init 0xFF) produced by `crc8to8_parallel`. It accepts a two-byte frame on a valid/ready byte stream: payload byte first, then CRC byte. It recomputes the CRC of the payload, compares it against the received CRC byte, and presents the payload downstream with an error flag. It also enforces an inter-byte timeout and keeps an optional saturating error count for status registers.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: number of idle cycles allowed between payload and CRC byte; 0 disables the timeout.
- `ERR_CNT_W`, default 8: width of the error counter.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `in_vld`  in  1  upstream byte valid.
- `in_data`  in  8  upstream byte.
- `in_rdy`  out  1  block can accept a byte.
- `out_vld`  out  1  checked frame available.
- `out_data`  out  8  payload byte.
- `out_crc_err`  out  1  1 = received CRC ≠ computed CRC.
- `out_rdy`  in  1  downstream accepts the frame.
- `timeout_pls`  out  1  one-cycle pulse when a frame is dropped on timeout.
- `err_cnt`  out  ERR_CNT_W  saturating count of CRC errors plus timeouts.
- `clr_err_cnt`  in  1  synchronous clear of `err_cnt`.

## Operation
- FSM states: IDLE, WAIT_CRC, OUT.
- IDLE:
  - `in_rdy`=1.
  - On `in_vld`, latch `in_data` into the payload register and go to WAIT_CRC.
- WAIT_CRC:
  - `in_rdy`=1; the timeout counter runs.
  - On `in_vld`, compare `in_data` against `crc8to8_parallel(payload)`.
  - Register `out_data`=payload and `out_crc_err`=(mismatch), then go to OUT.
- OUT:
  - `in_rdy`=0, `out_vld`=1.
  - `out_data` and `out_crc_err` hold stable until `out_rdy`=1; that cycle, go to IDLE.
- `in_rdy` is decoded from state only. It never depends on `in_vld` or `out_rdy`.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYC+1). Cleared on entry to WAIT_CRC.
  - Increments each WAIT_CRC cycle with `in_vld`=0.
  - If count == TIMEOUT_CYC-1 and `in_vld`=0, then: `timeout_pls`=1 for that cycle, payload discarded, next state IDLE, error event raised.
  - If `in_vld`=1 in that same cycle, the byte wins and no timeout occurs.
- Error event occurs on a CRC mismatch (at CRC-byte acceptance) or on a timeout. The two cannot coincide.
- Reset mid-frame: state→IDLE, partially received frame discarded, no error event.

## Timing
- Reset values:
  - `in_rdy`=1 (IDLE).
  - `out_vld`=0, `out_data`=0x00, `out_crc_err`=0.
  - `timeout_pls`=0, `err_cnt`=0, internal counters 0.
- Latency: CRC byte accepted in cycle N → `out_vld`=1 in cycle N+1.
- Throughput is at most one frame per 3 cycles: payload, CRC, output handshake with `out_rdy` already high.
- The `out_rdy` → IDLE transition takes effect the next cycle. A byte offered in the handshake cycle is not accepted.
- `err_cnt` updates one cycle after the error event. It saturates at all-ones.
- `clr_err_cnt` takes priority over a simultaneous increment; the result is 0.

## Configuration
- Macro `CRC8_FRAME_ERR_CNT_EN`.
- Defined: the error counter, increment logic and `clr_err_cnt` are present as described.
- Undefined:
  - `err_cnt` is tied to 0 and `clr_err_cnt` is ignored.
  - No counter flops are built.
  - `timeout_pls` and `out_crc_err` are unaffected.

## Structure
- Shared package `crc8_pkg` holds:
  - FSM state enum `crc8_chk_st_e` (IDLE, WAIT_CRC, OUT).
  - Constants `CRC8_POLY`=8'h2D and `CRC8_INIT`=8'hFF, for documentation and bench models.
- Sub-module: one instance of the existing `crc8to8_parallel`, fed from the payload register. The block has no local CRC equations.

## Test plan
- Good frame: send 0x00, then 0xA3; `out_rdy`=1 → `out_vld` one cycle after the CRC byte, `out_data`=0x00, `out_crc_err`=0, `err_cnt`=0.
- Bad frame: send 0xFF, then 0x01 → `out_data`=0xFF, `out_crc_err`=1, `err_cnt`=1. Then send 0xFF, 0x00 → `out_crc_err`=0, `err_cnt` stays 1.
- Backpressure: good frame with `out_rdy`=0 for 5 cycles → outputs stable throughout, `in_rdy`=0. Release → IDLE next cycle, next frame accepted.
- Timeout (TIMEOUT_CYC=4): payload, then 4 idle cycles → `timeout_pls` on the 4th idle cycle, `err_cnt`+1, no `out_vld`. A byte on the 4th idle cycle instead is taken as the CRC byte, with no timeout.
- Saturation and clear (ERR_CNT_W=2): 5 bad frames → `err_cnt`=3. Assert `clr_err_cnt` in the same cycle as a 6th error → `err_cnt`=0.
- Reset mid-frame: `rst` in WAIT_CRC → IDLE, no `out_vld`, `err_cnt` unchanged. The next good frame passes.

Source files
------------

// File: rtl/crc8_pkg.sv
// rtl/crc8_pkg.sv - shared types and constants for the CRC-8 frame checker
package crc8_pkg;

    // Frame checker states: waiting for payload, waiting for CRC byte, presenting result.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_CRC = 2'd1,
        OUT      = 2'd2
    } crc8_chk_st_e;

    // x^8 + x^5 + x^3 + x^2 + 1, with the implicit x^8 term dropped.
    localparam logic [7:0] CRC8_POLY = 8'h2D;
    localparam logic [7:0] CRC8_INIT = 8'hFF;

endpackage

// File: rtl/crc8to8_parallel.sv
// rtl/crc8to8_parallel.sv - single-byte CRC-8 (poly 0x2D, init 0xFF), MSB first
module crc8to8_parallel
    import crc8_pkg::*;
(
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [7:0] acc;

    // Unrolled MSB-first LFSR over one byte; the init value is folded into the data.
    always_comb begin
        acc = CRC8_INIT ^ data_i;
        for (int i = 0; i < 8; i++) begin
            if (acc[7]) begin
                acc = {acc[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                acc = {acc[6:0], 1'b0};
            end
        end
        crc_o = acc;
    end

endmodule

// File: rtl/crc8_frame_checker.sv
// rtl/crc8_frame_checker.sv - two-byte frame CRC checker; error counter built when CRC8_FRAME_ERR_CNT_EN is defined
module crc8_frame_checker
    import crc8_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [7:0]           in_data,
    output logic                 in_rdy,
    output logic                 out_vld,
    output logic [7:0]           out_data,
    output logic                 out_crc_err,
    input  logic                 out_rdy,
    output logic                 timeout_pls,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 clr_err_cnt
);

    // A zero TIMEOUT_CYC disables the timeout; keep the counter at least one bit wide.
    localparam bit              TO_EN   = (TIMEOUT_CYC > 0);
    localparam int              TO_W    = TO_EN ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TIMEOUT_CYC - 1) : '0;

    crc8_chk_st_e    state_q;
    logic [7:0]      payload_q;
    logic [7:0]      out_data_q;
    logic            out_crc_err_q;
    logic            out_vld_q;
    logic [TO_W-1:0] to_cnt_q;

    logic [7:0]      crc_calc;
    logic            crc_mismatch;
    logic            crc_accept;
    logic            timeout_hit;
    logic            err_evt;

    // The expected CRC is always derived from the stored payload byte.
    crc8to8_parallel u_crc (
        .data_i (payload_q),
        .crc_o  (crc_calc)
    );

    assign crc_mismatch = (in_data != crc_calc);
    assign crc_accept   = (state_q == WAIT_CRC) && in_vld;

    // A byte arriving on the last allowed idle cycle beats the timeout.
    assign timeout_hit  = TO_EN && (state_q == WAIT_CRC) && !in_vld && (to_cnt_q == TO_LAST);

    assign err_evt      = (crc_accept && crc_mismatch) || timeout_hit;

    // Frame sequencing: payload capture, CRC compare, output hold until handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            payload_q     <= 8'h00;
            out_data_q    <= 8'h00;
            out_crc_err_q <= 1'b0;
            out_vld_q     <= 1'b0;
            to_cnt_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_vld) begin
                        payload_q <= in_data;
                        to_cnt_q  <= '0;
                        state_q   <= WAIT_CRC;
                    end
                end
                WAIT_CRC: begin
                    if (in_vld) begin
                        out_data_q    <= payload_q;
                        out_crc_err_q <= crc_mismatch;
                        out_vld_q     <= 1'b1;
                        state_q       <= OUT;
                    end else if (timeout_hit) begin
                        to_cnt_q <= '0;
                        state_q  <= IDLE;
                    end else if (TO_EN) begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                OUT: begin
                    if (out_rdy) begin
                        out_vld_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_vld_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign in_rdy      = (state_q != OUT);
    assign out_vld     = out_vld_q;
    assign out_data    = out_data_q;
    assign out_crc_err = out_crc_err_q;
    assign timeout_pls = timeout_hit;

`ifdef CRC8_FRAME_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;

    // Saturating error count; a clear wins over a same-cycle error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_err_cnt) begin
            err_cnt_d = '0;
        end else if (err_evt && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_cnt_inputs;

    assign unused_err_cnt_inputs = clr_err_cnt ^ err_evt;
    assign err_cnt               = '0;
`endif

endmodule

// File: tb/tb_crc8_frame_checker.sv
// tb/tb_crc8_frame_checker.sv - self-checking bench for crc8_frame_checker
module tb_crc8_frame_checker;
    import crc8_pkg::*;

    localparam int TO = 4;
    localparam int CW = 2;
`ifdef CRC8_FRAME_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld;
    logic [7:0]    in_data;
    logic          in_rdy;
    logic          out_vld;
    logic [7:0]    out_data;
    logic          out_crc_err;
    logic          out_rdy;
    logic          timeout_pls;
    logic [CW-1:0] err_cnt;
    logic          clr_err_cnt;

    int checks    = 0;
    int failures  = 0;
    int model_cnt = 0;

    crc8_frame_checker #(
        .TIMEOUT_CYC (TO),
        .ERR_CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_vld      (in_vld),
        .in_data     (in_data),
        .in_rdy      (in_rdy),
        .out_vld     (out_vld),
        .out_data    (out_data),
        .out_crc_err (out_crc_err),
        .out_rdy     (out_rdy),
        .timeout_pls (timeout_pls),
        .err_cnt     (err_cnt),
        .clr_err_cnt (clr_err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Remainder of (byte ^ init) * x^8 modulo the full degree-8 generator.
    function automatic logic [7:0] ref_crc(input logic [7:0] d);
        logic [15:0] r;
        logic [15:0] g;
        r = {d ^ CRC8_INIT, 8'h00};
        g = {7'b0, 1'b1, CRC8_POLY};
        for (int b = 15; b >= 8; b--) begin
            if (r[b]) r = r ^ (g << (b - 8));
        end
        return r[7:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_bump();
        if (CNT_EN && model_cnt < (1 << CW) - 1) model_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] p, input logic [7:0] c, input int gap,
                         input int stall, input bit clr);
        logic exp_err;
        exp_err = (c != ref_crc(p));
        in_vld = 1'b1; in_data = p; out_rdy = 1'b0;
        @(negedge clk);
        chk("idle_in_rdy", in_rdy, 1);
        chk("idle_out_vld", out_vld, 0);
        tick();
        in_vld = 1'b0; in_data = 8'($urandom);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            chk("wait_timeout_pls", timeout_pls, 0);
            chk("wait_in_rdy", in_rdy, 1);
            chk("wait_out_vld", out_vld, 0);
            tick();
        end
        in_vld = 1'b1; in_data = c; out_rdy = (stall == 0); clr_err_cnt = clr;
        @(negedge clk);
        chk("crc_in_rdy", in_rdy, 1);
        chk("crc_no_timeout", timeout_pls, 0);
        chk("crc_out_vld", out_vld, 0);
        chk("crc_err_cnt_pre", err_cnt, model_cnt);
        tick();
        if (clr) model_cnt = 0;
        else if (exp_err) model_bump();
        clr_err_cnt = 1'b0;
        for (int s = 0; s <= stall; s++) begin
            in_vld = 1'($urandom_range(0, 1)); in_data = 8'($urandom);
            out_rdy = (s == stall);
            @(negedge clk);
            chk("out_vld", out_vld, 1);
            chk("out_data", out_data, p);
            chk("out_crc_err", out_crc_err, exp_err);
            chk("out_in_rdy", in_rdy, 0);
            chk("out_err_cnt", err_cnt, model_cnt);
            tick();
        end
        in_vld = 1'b0; out_rdy = 1'b0;
        @(negedge clk);
        chk("post_out_vld", out_vld, 0);
        chk("post_in_rdy", in_rdy, 1);
        chk("post_err_cnt", err_cnt, model_cnt);
        tick();
    endtask

    task automatic timeout_frame(input logic [7:0] p);
        in_vld = 1'b1; in_data = p; out_rdy = 1'b1;
        @(negedge clk);
        chk("to_idle_in_rdy", in_rdy, 1);
        tick();
        in_vld = 1'b0;
        for (int g = 1; g <= TO; g++) begin
            @(negedge clk);
            chk("to_pulse", timeout_pls, (g == TO));
            chk("to_out_vld", out_vld, 0);
            chk("to_err_cnt_pre", err_cnt, model_cnt);
            tick();
        end
        model_bump();
        @(negedge clk);
        chk("to_pulse_single", timeout_pls, 0);
        chk("to_after_out_vld", out_vld, 0);
        chk("to_after_in_rdy", in_rdy, 1);
        chk("to_after_err_cnt", err_cnt, model_cnt);
        tick();
        out_rdy = 1'b0;
    endtask

    function automatic logic [7:0] bad_crc(input logic [7:0] p);
        return ref_crc(p) ^ 8'($urandom_range(1, 255));
    endfunction

    initial begin
        logic [7:0] p;
        rst = 1'b1; in_vld = 1'b0; in_data = 8'h00; out_rdy = 1'b0; clr_err_cnt = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_crc_err", out_crc_err, 0);
        chk("rst_timeout_pls", timeout_pls, 0);
        chk("rst_err_cnt", err_cnt, 0);
        tick();
        rst = 1'b0;

        // Known-answer frames.
        frame(8'h00, 8'hA3, 0, 0, 1'b0);
        frame(8'hFF, 8'h01, 0, 0, 1'b0);
        frame(8'hFF, 8'h00, 1, 0, 1'b0);

        // Backpressure for five cycles, then an immediate next frame.
        p = 8'($urandom);
        frame(p, ref_crc(p), 1, 5, 1'b0);
        p = 8'($urandom);
        frame(p, ref_crc(p), 0, 0, 1'b0);

        // Timeout, then a CRC byte on the last idle cycle.
        timeout_frame(8'($urandom));
        p = 8'($urandom);
        frame(p, ref_crc(p), TO - 1, 0, 1'b0);

        // Saturation, then clear coinciding with an error.
        for (int i = 0; i < 5; i++) begin
            p = 8'($urandom);
            frame(p, bad_crc(p), i % TO, i % 3, 1'b0);
        end
        @(negedge clk);
        chk("sat_err_cnt", err_cnt, CNT_EN ? 3 : 0);
        tick();
        p = 8'($urandom);
        frame(p, bad_crc(p), 0, 1, 1'b1);

        // Reset while waiting for the CRC byte.
        in_vld = 1'b1; in_data = 8'($urandom);
        @(negedge clk);
        tick();
        in_vld = 1'b0; rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        model_cnt = 0;
        @(negedge clk);
        chk("mid_rst_in_rdy", in_rdy, 1);
        chk("mid_rst_out_vld", out_vld, 0);
        chk("mid_rst_err_cnt", err_cnt, model_cnt);
        chk("mid_rst_timeout", timeout_pls, 0);
        tick();
        p = 8'($urandom);
        frame(p, ref_crc(p), 0, 0, 1'b0);

        // Randomized frames with mixed gaps, stalls, errors, timeouts and clears.
        for (int i = 0; i < 40; i++) begin
            p = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                timeout_frame(p);
            end else begin
                frame(p, ($urandom_range(0, 1) == 1) ? ref_crc(p) : bad_crc(p),
                      $urandom_range(0, TO - 1), $urandom_range(0, 3),
                      ($urandom_range(0, 9) == 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
